// File: rtl/ps2_key_validator.sv
// PS/2 scan-code key validator: tracks make/break/extended prefixes and matches
// make codes against a parameterised key table, producing registered strobes and held flags.
module ps2_key_validator #(
    parameter int                         DATA_W     = 8,
    parameter int                         N_KEYS     = 3,
    parameter logic [DATA_W*N_KEYS-1:0]   KEY_CODES  = {8'h32, 8'h3A, 8'h1C},
    parameter logic [DATA_W-1:0]          BREAK_CODE = 8'hF0,
    parameter logic [DATA_W-1:0]          EXT_CODE   = 8'hE0,
    parameter bit                         REPEAT_EN  = 1'b0,
    parameter int                         IDX_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] dato_in,
    input  logic              Listo,
    output logic [N_KEYS-1:0] enable,
    output logic [IDX_W-1:0]  key_idx,
    output logic              key_valid,
    output logic [N_KEYS-1:0] held,
    output logic              unknown
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t             state;
    state_t             stateNext;

    logic [DATA_W-1:0]  byteQ;
    logic               validQ;

    logic               matchHit;
    logic [IDX_W-1:0]   matchIdx;
    logic [N_KEYS-1:0]  matchOneHot;

    logic [N_KEYS-1:0]  enableNext;
    logic [IDX_W-1:0]   keyIdxNext;
    logic               keyValidNext;
    logic [N_KEYS-1:0]  heldNext;
    logic               unknownNext;

    // The incoming byte is captured first, so the decision for a byte lands one
    // edge after it was sampled and every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byteQ  <= '0;
            validQ <= 1'b0;
        end else begin
            byteQ  <= dato_in;
            validQ <= Listo;
        end
    end

    // Table search runs from the top index down so the lowest duplicate wins.
    always_comb begin
        matchHit    = 1'b0;
        matchIdx    = '0;
        matchOneHot = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (byteQ == KEY_CODES[DATA_W*i +: DATA_W]) begin
                matchHit       = 1'b1;
                matchIdx       = IDX_W'(i);
                matchOneHot    = '0;
                matchOneHot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        stateNext    = state;
        enableNext   = '0;
        keyIdxNext   = key_idx;
        keyValidNext = 1'b0;
        heldNext     = held;
        unknownNext  = 1'b0;

        if (validQ) begin
            case (state)
                IDLE: begin
                    if (byteQ == EXT_CODE) begin
                        stateNext = EXT;
                    end else if (byteQ == BREAK_CODE) begin
                        stateNext = BRK;
                    end else if (matchHit) begin
                        heldNext = held | matchOneHot;
                        // Typematic repeats of an already-held key stay silent unless enabled.
                        if (REPEAT_EN || ((held & matchOneHot) == '0)) begin
                            enableNext   = matchOneHot;
                            keyValidNext = 1'b1;
                            keyIdxNext   = matchIdx;
                        end
                    end else begin
                        unknownNext = 1'b1;
                    end
                end
                BRK: begin
                    heldNext  = held & ~matchOneHot;
                    stateNext = IDLE;
                end
                EXT: begin
                    stateNext = (byteQ == BREAK_CODE) ? EXT_BRK : IDLE;
                end
                EXT_BRK: begin
                    stateNext = IDLE;
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            enable    <= '0;
            key_idx   <= '0;
            key_valid <= 1'b0;
            held      <= '0;
            unknown   <= 1'b0;
        end else begin
            state     <= stateNext;
            enable    <= enableNext;
            key_idx   <= keyIdxNext;
            key_valid <= keyValidNext;
            held      <= heldNext;
            unknown   <= unknownNext;
        end
    end

endmodule

// File: tb/tb_ps2_key_validator.sv
// Directed bench for ps2_key_validator: default table, a repeat-enabled copy and a
// copy with a duplicated table entry, all driven from the same byte stream.
module tb_ps2_key_validator;

    logic       clk;
    logic       rst;
    logic [7:0] dato_in;
    logic       Listo;

    logic [2:0] enable,    enableRep,   enableDup;
    logic [2:0] keyIdx,    keyIdxRep,   keyIdxDup;
    logic       keyValid,  keyValidRep, keyValidDup;
    logic [2:0] held,      heldRep,     heldDup;
    logic       unknown,   unknownRep,  unknownDup;

    int compared   = 0;
    int mismatched = 0;

    ps2_key_validator dut (
        .clk(clk), .rst(rst), .dato_in(dato_in), .Listo(Listo),
        .enable(enable), .key_idx(keyIdx), .key_valid(keyValid),
        .held(held), .unknown(unknown)
    );

    ps2_key_validator #(.REPEAT_EN(1'b1)) dutRep (
        .clk(clk), .rst(rst), .dato_in(dato_in), .Listo(Listo),
        .enable(enableRep), .key_idx(keyIdxRep), .key_valid(keyValidRep),
        .held(heldRep), .unknown(unknownRep)
    );

    // Entries 0 and 1 are both 3A; entry 2 is 1C.
    ps2_key_validator #(.KEY_CODES(24'h1C3A3A)) dutDup (
        .clk(clk), .rst(rst), .dato_in(dato_in), .Listo(Listo),
        .enable(enableDup), .key_idx(keyIdxDup), .key_valid(keyValidDup),
        .held(heldDup), .unknown(unknownDup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkField(input string tag, input string field,
                              input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] expEn,
                               input logic expValid, input logic [2:0] expIdx,
                               input logic [2:0] expHeld, input logic expUnk);
        checkField(tag, "enable",    {5'b0, enable},   {5'b0, expEn});
        checkField(tag, "key_valid", {7'b0, keyValid}, {7'b0, expValid});
        checkField(tag, "key_idx",   {5'b0, keyIdx},   {5'b0, expIdx});
        checkField(tag, "held",      {5'b0, held},     {5'b0, expHeld});
        checkField(tag, "unknown",   {7'b0, unknown},  {7'b0, expUnk});
    endtask

    task automatic checkRep(input string tag, input logic [2:0] expEn,
                            input logic expValid, input logic [2:0] expHeld);
        checkField(tag, "rep.enable",    {5'b0, enableRep},   {5'b0, expEn});
        checkField(tag, "rep.key_valid", {7'b0, keyValidRep}, {7'b0, expValid});
        checkField(tag, "rep.held",      {5'b0, heldRep},     {5'b0, expHeld});
    endtask

    // Drives one cycle of input, then returns 1 time unit after the sampling edge;
    // outputs seen then belong to the byte driven on the previous call.
    task automatic applyStimulus(input logic v, input logic [7:0] b);
        @(negedge clk);
        Listo   = v;
        dato_in = b;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] extSeq [6];
    logic       extVal [6];

    initial begin
        rst     = 1'b0;
        Listo   = 1'b0;
        dato_in = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset", 3'b000, 1'b0, 3'd0, 3'b000, 1'b0);
        checkRep("reset", 3'b000, 1'b0, 3'b000);
        rst = 1'b1;

        // Single make of key 0
        applyStimulus(1'b1, 8'h1C);
        applyStimulus(1'b0, 8'h00);
        checkOutput("make1C", 3'b001, 1'b1, 3'd0, 3'b001, 1'b0);
        applyStimulus(1'b0, 8'h00);
        checkOutput("make1C_after", 3'b000, 1'b0, 3'd0, 3'b001, 1'b0);

        // Break of key 0
        applyStimulus(1'b1, 8'hF0);
        checkOutput("brk_a", 3'b000, 1'b0, 3'd0, 3'b001, 1'b0);
        applyStimulus(1'b1, 8'h1C);
        checkOutput("brk_b", 3'b000, 1'b0, 3'd0, 3'b001, 1'b0);
        applyStimulus(1'b0, 8'h00);
        checkOutput("brk_c", 3'b000, 1'b0, 3'd0, 3'b000, 1'b0);

        // Typematic repeat of 3A, three back-to-back bytes
        applyStimulus(1'b1, 8'h3A);
        applyStimulus(1'b1, 8'h3A);
        checkOutput("rpt1", 3'b010, 1'b1, 3'd1, 3'b010, 1'b0);
        checkRep("rpt1", 3'b010, 1'b1, 3'b010);
        checkField("dup", "enable",  {5'b0, enableDup}, 8'h01);
        checkField("dup", "key_idx", {5'b0, keyIdxDup}, 8'h00);
        applyStimulus(1'b1, 8'h3A);
        checkOutput("rpt2", 3'b000, 1'b0, 3'd1, 3'b010, 1'b0);
        checkRep("rpt2", 3'b010, 1'b1, 3'b010);
        applyStimulus(1'b0, 8'h00);
        checkOutput("rpt3", 3'b000, 1'b0, 3'd1, 3'b010, 1'b0);
        checkRep("rpt3", 3'b010, 1'b1, 3'b010);
        applyStimulus(1'b0, 8'h00);
        checkRep("rpt4", 3'b000, 1'b0, 3'b010);

        // Extended make and extended break leave every output alone
        extSeq = '{8'hE0, 8'h1C, 8'hE0, 8'hF0, 8'h1C, 8'h00};
        extVal = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(extVal[i], extSeq[i]);
            checkOutput("ext", 3'b000, 1'b0, 3'd1, 3'b010, 1'b0);
        end
        applyStimulus(1'b1, 8'h32);
        applyStimulus(1'b0, 8'h00);
        checkOutput("make32", 3'b100, 1'b1, 3'd2, 3'b110, 1'b0);

        // Unknown make, then break of an unknown code
        applyStimulus(1'b1, 8'h55);
        applyStimulus(1'b0, 8'h00);
        checkOutput("unk55", 3'b000, 1'b0, 3'd2, 3'b110, 1'b1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("unk55_after", 3'b000, 1'b0, 3'd2, 3'b110, 1'b0);
        applyStimulus(1'b1, 8'hF0);
        applyStimulus(1'b1, 8'h55);
        applyStimulus(1'b0, 8'h00);
        checkOutput("brk55", 3'b000, 1'b0, 3'd2, 3'b110, 1'b0);

        // F0 F0 1C: second F0 is break data, no prefix stacking, 1C is a make
        applyStimulus(1'b1, 8'hF0);
        applyStimulus(1'b1, 8'hF0);
        applyStimulus(1'b1, 8'h1C);
        checkOutput("f0f0", 3'b000, 1'b0, 3'd2, 3'b110, 1'b0);
        applyStimulus(1'b0, 8'h00);
        checkOutput("f0f0_1C", 3'b001, 1'b1, 3'd0, 3'b111, 1'b0);
        checkRep("f0f0_1C", 3'b001, 1'b1, 3'b111);

        // Reset in the middle of a break sequence
        applyStimulus(1'b1, 8'h1C);
        applyStimulus(1'b1, 8'hF0);
        @(negedge clk);
        Listo = 1'b0;
        rst   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midrst", 3'b000, 1'b0, 3'd0, 3'b000, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 8'h1C);
        applyStimulus(1'b0, 8'h00);
        checkOutput("postrst", 3'b001, 1'b1, 3'd0, 3'b001, 1'b0);
        checkRep("postrst", 3'b001, 1'b1, 3'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ps2_key_validator.md
Name: ps2_key_validator

Overview:
Parametrised successor to the single-byte key validator on the PS/2 keyboard path. Consumes scan-code bytes from the PS/2 receiver, tracks the make/break/extended prefix protocol with a small FSM and matches make codes against a configurable key table. Produces registered one-hot key strobes, per-key held flags and a no-match indication for the downstream control logic.

Parameters:
DATA_W, 8, scan-code byte width
N_KEYS, 3, number of table entries (1..8)
KEY_CODES, {8'h32,8'h3A,8'h1C}, packed table; entry i = KEY_CODES[DATA_W*i +: DATA_W] (default: idx0=1C, idx1=3A, idx2=32)
BREAK_CODE, 8'hF0, break prefix byte
EXT_CODE, 8'hE0, extended prefix byte
REPEAT_EN, 0, 1 = typematic repeat of a held key re-pulses enable; 0 = suppressed
IDX_W, 3, width of key_idx (>= clog2(N_KEYS), min 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
dato_in  in  DATA_W  scan-code byte from PS/2 receiver
Listo  in  1  byte-valid strobe; dato_in sampled on each cycle Listo=1
enable  out  N_KEYS  one-hot make strobe, one cycle wide
key_idx  out  IDX_W  index of last matched make; holds between events
key_valid  out  1  one-cycle pulse accompanying any enable pulse
held  out  N_KEYS  level: key i is down (make seen, break not yet seen)
unknown  out  1  one-cycle pulse: non-extended make byte matched no entry

Behaviour:
- Reset (rst=0, async): FSM=IDLE; enable=0, key_valid=0, key_idx=0, held=0, unknown=0. Release synchronous to clk.
- All outputs registered; byte sampled at edge n (Listo=1) -> response visible after edge n+1 (latency 1). enable/key_valid/unknown are 0 on every cycle without a response.
- Listo high on consecutive cycles = consecutive bytes, each processed; no back-pressure.
- FSM states: IDLE, BRK, EXT, EXT_BRK. Transitions only when Listo=1:
  - IDLE: byte==EXT_CODE -> EXT; byte==BREAK_CODE -> BRK; else make-process byte, stay IDLE.
  - BRK: break-process byte -> IDLE.
  - EXT: byte==BREAK_CODE -> EXT_BRK; else discard (no outputs) -> IDLE.
  - EXT_BRK: discard -> IDLE.
- Make-process: search table; lowest index wins on duplicate entries. Match i: set held[i]; pulse enable[i], key_valid, load key_idx=i — unless held[i] already 1 and REPEAT_EN=0 (then no pulse, key_idx unchanged). No match: pulse unknown; held unchanged.
- Break-process: match i -> clear held[i], no pulses. No match -> ignored (unknown not raised).
- Extended sequences never touch any output (E0 1C is not key 0).
- Prefix followed by another prefix: in BRK, byte F0 or E0 is treated as data (matched normally, normally no match) -> IDLE; no stacking.
- Reset mid-sequence: prefix state lost; next byte interpreted from IDLE.
- enable is one-hot or zero by construction; never more than one bit set.
- Only DATA_W bits compared; no X propagation from unused KEY_CODES bits.

Test Plan:
- Reset then Listo pulse with 8'h1C -> one cycle later enable=3'b001, key_valid=1, key_idx=0, held=3'b001; next cycle enable=0, key_valid=0.
- Bytes F0,1C after the above -> held=3'b000, enable/key_valid/unknown stay 0 throughout.
- REPEAT_EN=0: bytes 3A,3A,3A back-to-back (Listo high 3 cycles) -> exactly one enable=3'b010 pulse, held=3'b010; repeat with REPEAT_EN=1 -> three pulses on consecutive cycles.
- Bytes E0,1C then E0,F0,1C -> no enable, no unknown, held unchanged; following 32 -> enable=3'b100, key_idx=2.
- Byte 8'h55 -> unknown pulses one cycle, enable=0, key_idx unchanged; F0,55 -> no pulses.
- Bytes 1C, F0 then rst low 2 cycles, release, byte 1C -> after reset all outputs 0; 1C treated as make: enable=3'b001, held=3'b001.
